sync_fifo_mem: RTL and testbench
================================

SYNC_FIFO_MEM -- requirements
Module: sync_fifo_mem

Interface
REQ-001 Parameter DATA_WIDTH, default 6: word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 3: pointer width; DEPTH = 2**ADDR_WIDTH entries.
REQ-003 Parameter ALMOST_FULL_LVL, default DEPTH-2: oAlmostFull threshold, 1..DEPTH-1.
REQ-004 Parameter ALMOST_EMPTY_LVL, default 2: oAlmostEmpty threshold, 1..DEPTH-1.
REQ-005 Clock  in  1  single clock; all state changes on the rising edge.
REQ-006 Reset  in  1  asynchronous, active-high reset.
REQ-007 iPush  in  1  write request.
REQ-008 iPop  in  1  read request.
REQ-009 iDataIn  in  DATA_WIDTH  write data, sampled on an accepted push.
REQ-010 oDataOut  out  DATA_WIDTH  registered read data.
REQ-011 oValid  out  1  high for one cycle when oDataOut carries a newly popped word.
REQ-012 oFull / oEmpty  out  1 each  occupancy == DEPTH / occupancy == 0.
REQ-013 oAlmostFull / oAlmostEmpty  out  1 each  count >= ALMOST_FULL_LVL / count <= ALMOST_EMPTY_LVL.
REQ-014 oCount  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
REQ-015 oOverflow / oUnderflow  out  1 each  sticky error flags.

Function
REQ-016 Push accepted when iPush=1 and (oFull=0 or pop accepted in the same cycle); data written at write pointer, pointer +1 modulo DEPTH.
REQ-017 Pop accepted when iPop=1 and oEmpty=0; head word loaded into oDataOut at that edge, oValid=1 the following cycle only, read pointer +1 modulo DEPTH.
REQ-018 Pop latency: exactly one clock from accepted pop to oDataOut/oValid; oDataOut holds its value when no pop is accepted.
REQ-019 Occupancy state machine states EMPTY, PARTIAL, FULL: EMPTY->PARTIAL on push-only; PARTIAL->FULL when push-only makes count DEPTH; FULL->PARTIAL on pop; PARTIAL->EMPTY when pop-only makes count 0; push+pop holds state and count.
REQ-020 Push+pop while FULL: both accepted; popped word is the oldest; count stays DEPTH.
REQ-021 Push+pop while EMPTY: push accepted, pop rejected, oUnderflow set; count becomes 1 (no write-through bypass).
REQ-022 Rejected push (full, no pop) drops data, pointers unchanged, oOverflow set.
REQ-023 Rejected pop (empty) leaves oDataOut unchanged, oValid=0, oUnderflow set.
REQ-024 oOverflow/oUnderflow stay high until Reset.
REQ-025 Flags and oCount registered, consistent with the same edge's pointer update; pointer wrap is transparent to count.

Reset
REQ-026 Reset asserted: pointers=0, oCount=0, state EMPTY, oEmpty=1, oAlmostEmpty=1, oFull=0, oAlmostFull=0, oValid=0, oDataOut=0, oOverflow=0, oUnderflow=0, immediately without a clock edge.
REQ-027 Memory array contents are not reset; reset mid-operation discards all stored words.
REQ-028 Push/pop requests in the first edge after Reset deasserts are processed normally.

Structure
REQ-029 Shared package sync_fifo_pkg holds default DATA_WIDTH/ADDR_WIDTH/thresholds and the occupancy state encoding.
REQ-030 One sub-module fifo_ram: parametrised 1-write/1-read array, synchronous write, combinational read by address, no reset.

Verification (DATA_WIDTH=6, ADDR_WIDTH=3, AF=6, AE=2)
REQ-031 Reset, then push 0x01..0x08 -> oCount=8, oFull=1, oAlmostFull=1 after 6th push; pop 8 -> oDataOut 0x01..0x08 in order, oValid one cycle after each pop, oEmpty=1.
REQ-032 Full FIFO, push 0x3F without pop -> oOverflow=1, oCount=8; later pops never return 0x3F.
REQ-033 Full FIFO, push 0x2A with pop -> oDataOut=oldest word, oCount=8, 0x2A popped last.
REQ-034 Empty FIFO, push 0x15 with pop -> oUnderflow=1, oValid=0, oCount=1; next pop returns 0x15.
REQ-035 20 push-pop pairs at count 3 -> pointers wrap twice, order preserved, oCount constant 3.
REQ-036 Reset asserted mid-cycle at count 5 -> all outputs at reset values before next edge; next pop with no push sets oUnderflow.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared defaults and occupancy state encoding for the synchronous FIFO.
package sync_fifo_pkg;
  localparam int DEF_DATA_WIDTH = 6;
  localparam int DEF_ADDR_WIDTH = 3;
  localparam int DEF_AE_LVL     = 2;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occState_t;
endpackage

// File: rtl/fifo_ram.sv
// 1-write/1-read storage array: synchronous write, combinational read, no reset.
module fifo_ram #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  Clock,
  input  logic                  wEn,
  input  logic [ADDR_WIDTH-1:0] wAddr,
  input  logic [DATA_WIDTH-1:0] wData,
  input  logic [ADDR_WIDTH-1:0] rAddr,
  output logic [DATA_WIDTH-1:0] rData
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge Clock) begin
    if (wEn) mem[wAddr] <= wData;
  end

  assign rData = mem[rAddr];
endmodule

// File: rtl/sync_fifo_mem.sv
// Synchronous FIFO with registered read data, occupancy FSM, registered flags
// and sticky overflow/underflow.
module sync_fifo_mem import sync_fifo_pkg::*; #(
  parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH       = DEF_ADDR_WIDTH,
  parameter int ALMOST_FULL_LVL  = (2**ADDR_WIDTH) - 2,
  parameter int ALMOST_EMPTY_LVL = DEF_AE_LVL
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iPush,
  input  logic                  iPop,
  input  logic [DATA_WIDTH-1:0] iDataIn,
  output logic [DATA_WIDTH-1:0] oDataOut,
  output logic                  oValid,
  output logic                  oFull,
  output logic                  oEmpty,
  output logic                  oAlmostFull,
  output logic                  oAlmostEmpty,
  output logic [ADDR_WIDTH:0]   oCount,
  output logic                  oOverflow,
  output logic                  oUnderflow
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(2**ADDR_WIDTH);
  localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL_LVL);
  localparam logic [CW-1:0] AE_C    = CW'(ALMOST_EMPTY_LVL);

  occState_t             state;
  logic [ADDR_WIDTH-1:0] wrPtr, rdPtr;
  logic [DATA_WIDTH-1:0] headData;
  logic                  pushAcc, popAcc;
  logic [CW-1:0]         cntNext;

  // A full FIFO still takes a push when a pop frees the slot on the same edge.
  assign popAcc  = iPop && (state != OCC_EMPTY);
  assign pushAcc = iPush && ((state != OCC_FULL) || popAcc);

  always_comb begin
    cntNext = oCount;
    case ({pushAcc, popAcc})
      2'b10:   cntNext = oCount + CW'(1);
      2'b01:   cntNext = oCount - CW'(1);
      default: cntNext = oCount;
    endcase
  end

  fifo_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) uRam (
    .Clock (Clock),
    .wEn   (pushAcc),
    .wAddr (wrPtr),
    .wData (iDataIn),
    .rAddr (rdPtr),
    .rData (headData)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state        <= OCC_EMPTY;
      wrPtr        <= '0;
      rdPtr        <= '0;
      oCount       <= '0;
      oDataOut     <= '0;
      oValid       <= 1'b0;
      oFull        <= 1'b0;
      oEmpty       <= 1'b1;
      oAlmostFull  <= 1'b0;
      oAlmostEmpty <= 1'b1;
      oOverflow    <= 1'b0;
      oUnderflow   <= 1'b0;
    end else begin
      if (pushAcc) wrPtr <= wrPtr + ADDR_WIDTH'(1);
      if (popAcc) begin
        rdPtr    <= rdPtr + ADDR_WIDTH'(1);
        oDataOut <= headData;
      end
      oValid <= popAcc;

      case (state)
        OCC_EMPTY:   if (pushAcc && !popAcc) state <= OCC_PARTIAL;
        OCC_PARTIAL: if (pushAcc != popAcc)
                       state <= (cntNext == DEPTH_C) ? OCC_FULL :
                                (cntNext == '0)      ? OCC_EMPTY : OCC_PARTIAL;
        OCC_FULL:    if (popAcc && !pushAcc) state <= OCC_PARTIAL;
        default:     state <= OCC_EMPTY;
      endcase

      oCount       <= cntNext;
      oFull        <= (cntNext == DEPTH_C);
      oEmpty       <= (cntNext == '0);
      oAlmostFull  <= (cntNext >= AF_C);
      oAlmostEmpty <= (cntNext <= AE_C);
      if (iPush && !pushAcc) oOverflow  <= 1'b1;
      if (iPop && !popAcc)   oUnderflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sync_fifo_mem.sv
// Scoreboard bench for sync_fifo_mem: a queue model predicts contents, flags
// and popped words; every output is checked each cycle.
module tb_sync_fifo_mem;
  localparam int DW = 6, AW = 3, DEPTH = 8, AF = 6, AE = 2;

  logic          Clock = 1'b0, Reset = 1'b1, iPush = 1'b0, iPop = 1'b0;
  logic [DW-1:0] iDataIn = '0;
  logic [DW-1:0] oDataOut;
  logic          oValid, oFull, oEmpty, oAlmostFull, oAlmostEmpty;
  logic [AW:0]   oCount;
  logic          oOverflow, oUnderflow;

  sync_fifo_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ALMOST_FULL_LVL(AF),
                  .ALMOST_EMPTY_LVL(AE)) dut (
    .Clock(Clock), .Reset(Reset), .iPush(iPush), .iPop(iPop), .iDataIn(iDataIn),
    .oDataOut(oDataOut), .oValid(oValid), .oFull(oFull), .oEmpty(oEmpty),
    .oAlmostFull(oAlmostFull), .oAlmostEmpty(oAlmostEmpty), .oCount(oCount),
    .oOverflow(oOverflow), .oUnderflow(oUnderflow)
  );

  always #5 Clock = ~Clock;

  int            total = 0, bad = 0;
  logic [DW-1:0] mdl[$];
  logic [DW-1:0] expQ[$];
  logic [DW-1:0] lastOut = '0;
  bit            mOvf = 1'b0, mUnf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkAll(input string tag, input bit vld);
    int n;
    n = mdl.size();
    chk({tag, ".valid"}, 32'(oValid), 32'(vld));
    if (vld && expQ.size() > 0) lastOut = expQ.pop_front();
    chk({tag, ".data"},  32'(oDataOut),     32'(lastOut));
    chk({tag, ".count"}, 32'(oCount),       32'(n));
    chk({tag, ".full"},  32'(oFull),        32'(n == DEPTH));
    chk({tag, ".empty"}, 32'(oEmpty),       32'(n == 0));
    chk({tag, ".afull"}, 32'(oAlmostFull),  32'(n >= AF));
    chk({tag, ".aempty"},32'(oAlmostEmpty), 32'(n <= AE));
    chk({tag, ".ovf"},   32'(oOverflow),    32'(mOvf));
    chk({tag, ".unf"},   32'(oUnderflow),   32'(mUnf));
  endtask

  task automatic mdlReset();
    mdl.delete();
    expQ.delete();
    lastOut = '0;
    mOvf = 1'b0;
    mUnf = 1'b0;
  endtask

  task automatic step(input string tag, input bit push, input bit pop, input logic [DW-1:0] d);
    bit popOk, pushOk;
    @(negedge Clock);
    iPush = push; iPop = pop; iDataIn = d;
    popOk  = pop && (mdl.size() > 0);
    pushOk = push && ((mdl.size() < DEPTH) || popOk);
    if (popOk)  expQ.push_back(mdl.pop_front());
    if (pushOk) mdl.push_back(d);
    if (push && !pushOk) mOvf = 1'b1;
    if (pop && !popOk)   mUnf = 1'b1;
    @(posedge Clock);
    #1;
    iPush = 1'b0; iPop = 1'b0;
    checkAll(tag, popOk);
  endtask

  initial begin
    #12;
    mdlReset();
    checkAll("rst", 1'b0);
    @(negedge Clock);
    Reset = 1'b0;

    // Fill, then drain in order.
    for (int i = 1; i <= 8; i++) step("fill", 1'b1, 1'b0, DW'(i));
    for (int i = 0; i < 8; i++)  step("drain", 1'b0, 1'b1, '0);
    step("idle", 1'b0, 1'b0, '0);

    // Overflow on full, then push+pop while full.
    for (int i = 1; i <= 8; i++) step("refill", 1'b1, 1'b0, DW'(i));
    step("ovf", 1'b1, 1'b0, 6'h3F);
    step("fullpp", 1'b1, 1'b1, 6'h2A);
    for (int i = 0; i < 8; i++) step("drain2", 1'b0, 1'b1, '0);

    // Push+pop on empty: pop rejected, push lands.
    step("emptypp", 1'b1, 1'b1, 6'h15);
    step("pop15", 1'b0, 1'b1, '0);

    // Clear sticky flags, then 20 push/pop pairs at count 3 to wrap pointers.
    @(negedge Clock);
    Reset = 1'b1;
    mdlReset();
    #1;
    checkAll("rst2", 1'b0);
    @(negedge Clock);
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) step("pre", 1'b1, 1'b0, DW'(6'h30 + i));
    for (int i = 0; i < 20; i++) step("wrap", 1'b1, 1'b1, DW'($urandom_range(0, 63)));

    // Mid-cycle reset at count 5 takes effect without a clock edge.
    step("to5a", 1'b1, 1'b0, 6'h0A);
    step("to5b", 1'b1, 1'b0, 6'h0B);
    chk("cnt5", 32'(oCount), 32'd5);
    #2;
    Reset = 1'b1;
    mdlReset();
    #1;
    checkAll("midrst", 1'b0);
    @(negedge Clock);
    Reset = 1'b0;
    step("unfpop", 1'b0, 1'b1, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
